qmult_arbiter: RTL and testbench

QMULT_ARBITER -- requirements
Module: qmult_arbiter

---
 rtl/qmult_arbiter_pkg.sv | 6 +
 rtl/qmult_arbiter_rr_pick.sv | 28 ++
 rtl/qmult_arbiter.sv | 99 +++++++++
 tb/tb_qmult_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/qmult_arbiter_pkg.sv
// qmult_arbiter_pkg: FSM state encoding and default Q-format widths
package qmult_arbiter_pkg;
  localparam int N_DEF = 32;
  localparam int Q_DEF = 15;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_t;
endpackage

// File: rtl/qmult_arbiter_rr_pick.sv
// rr_pick: round-robin winner, searching upward from last+1 with wrap
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  int d, best;
  always_comb begin
    idx = '0;
    any = 1'b0;
    best = NREQ;
    d = 0;
    for (int k = 0; k < NREQ; k++) begin
      d = k > int'(last) ? k - int'(last) - 1 : k + NREQ - int'(last) - 1;
      if (req[k] && d < best) begin
        best = d;
        idx = IW'(k);
        any = 1'b1;
      end
    end
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/qmult_arbiter.sv
// qmult_arbiter: round-robin sharing of one serial Q-format multiplier among NREQ requesters
module qmult_arbiter
  import qmult_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF,
  parameter int NREQ = 4,
  parameter int TIMEOUT = 4 * N
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_multiplicand,
  input  logic [NREQ*N-1:0] i_multiplier,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_valid,
  output logic [N-1:0]      o_result,
  output logic              o_overflow,
  output logic              o_error,
  output logic [N-1:0]      o_mul_multiplicand,
  output logic [N-1:0]      o_mul_multiplier,
  output logic              o_mul_start,
  input  logic [N-1:0]      i_mul_result,
  input  logic              i_mul_complete,
  input  logic              i_mul_overflow
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t          state;
  logic [IW-1:0]   last_served, idx;
  logic [WW-1:0]   wdog;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any, timeout;
  if (Q >= N) begin : g_q_chk
    $error("Q must be smaller than N");
  end
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (i_req),
    .last(last_served),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );
  assign timeout = wdog == WW'(TIMEOUT - 1);
  // the watchdog covers both an unacknowledged start and a hung multiplier
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      last_served <= IW'(NREQ - 1);
      idx <= '0;
      wdog <= '0;
      o_gnt <= '0;
      o_valid <= '0;
      o_result <= '0;
      o_overflow <= 1'b0;
      o_error <= 1'b0;
      o_mul_start <= 1'b0;
      o_mul_multiplicand <= '0;
      o_mul_multiplier <= '0;
    end else begin
      o_mul_start <= 1'b0;
      o_valid <= '0;
      o_error <= 1'b0;
      case (state)
        IDLE: if (pick_any && i_mul_complete) begin
          o_gnt <= pick_gnt;
          idx <= pick_idx;
          o_mul_multiplicand <= i_multiplicand[pick_idx*N +: N];
          o_mul_multiplier <= i_multiplier[pick_idx*N +: N];
          o_mul_start <= 1'b1;
          wdog <= '0;
          state <= ISSUE;
        end
        ISSUE: state <= WAIT_ACK;
        WAIT_ACK, WAIT_DONE:
          if (state == WAIT_DONE && i_mul_complete) begin
            o_result <= i_mul_result;
            o_overflow <= i_mul_overflow;
            o_valid <= o_gnt;
            state <= RESP;
          end else if (timeout) begin
            o_error <= 1'b1;
            o_gnt <= '0;
            last_served <= idx;
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
            if (state == WAIT_ACK && !i_mul_complete) state <= WAIT_DONE;
          end
        RESP: begin
          o_gnt <= '0;
          last_served <= idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_qmult_arbiter.sv
// tb_qmult_arbiter: directed scoreboard bench with a behavioural serial multiplier
module tb_qmult_arbiter;
  localparam int N = 32, NREQ = 4, TIMEOUT = 4 * N, BUSY = 5;
  typedef struct packed {logic err; logic [3:0] vld; logic [31:0] res; logic ovf;} exp_t;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic [3:0] i_req = '0;
  logic [127:0] mcand = '0, mplier = '0;
  logic [3:0] o_gnt, o_valid;
  logic [31:0] o_result, o_mul_multiplicand, o_mul_multiplier;
  logic o_overflow, o_error, o_mul_start;
  logic mul_complete = 1'b1, mul_ovf = 1'b0, stuck = 1'b0, force_ovf = 1'b0;
  logic [31:0] mul_res = '0;
  logic [63:0] prod;
  int busy = 0, tests = 0, fails = 0, cyc = 0, t_start = 0, n = 0;
  exp_t sb[$];
  exp_t e;
  always #5 i_clk = ~i_clk;
  qmult_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
    .i_multiplicand(mcand), .i_multiplier(mplier),
    .o_gnt(o_gnt), .o_valid(o_valid), .o_result(o_result), .o_overflow(o_overflow),
    .o_error(o_error), .o_mul_multiplicand(o_mul_multiplicand), .o_mul_multiplier(o_mul_multiplier),
    .o_mul_start(o_mul_start), .i_mul_result(mul_res), .i_mul_complete(mul_complete),
    .i_mul_overflow(mul_ovf)
  );
  // sign-magnitude Q15 multiplier, busy for BUSY cycles or forever while stuck; never reset
  assign prod = ({33'b0, o_mul_multiplicand[30:0]} * {33'b0, o_mul_multiplier[30:0]}) >> 15;
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_mul_start && mul_complete) begin
      busy <= stuck ? -1 : BUSY;
      mul_complete <= 1'b0;
      mul_res <= {o_mul_multiplicand[31] ^ o_mul_multiplier[31], prod[30:0]};
      mul_ovf <= force_ovf | (|prod[63:31]);
    end else if (busy > 0) begin
      if (busy == 1) mul_complete <= 1'b1;
      busy <= busy - 1;
    end else if (busy < 0 && !stuck) begin
      mul_complete <= 1'b1;
      busy <= 0;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge i_clk) if (i_rst_n) begin
    if (o_mul_start) t_start <= cyc;
    if (o_valid != 0 || o_error) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: valid=%b error=%b with nothing expected", o_valid, o_error);
      end else begin
        e = sb.pop_front();
        chk("error", o_error, e.err);
        chk("valid", o_valid, e.vld);
        if (e.err) chk("error_delay", (cyc - t_start >= TIMEOUT) && (cyc - t_start <= TIMEOUT + 2), 1);
        else begin
          chk("result", o_result, e.res);
          chk("overflow", o_overflow, e.ovf);
        end
      end
    end
  end
  task automatic expect_v(input logic [3:0] v, input logic [31:0] r, input logic o);
    sb.push_back('{err: 1'b0, vld: v, res: r, ovf: o});
  endtask
  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
    mcand[k*32 +: 32] = a;
    mplier[k*32 +: 32] = b;
  endtask
  task automatic reset_dut();
    i_rst_n = 1'b0;
    i_req = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_gnt", o_gnt, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_flags", {o_overflow, o_error, o_mul_start}, 0);
    chk("rst_ops", {o_mul_multiplicand, o_mul_multiplier}, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
  endtask
  task automatic serve(input logic [3:0] r);
    i_req = r;
    for (int i = 0; i < 1000 && i_req != 0; i++) begin
      @(negedge i_clk);
      i_req = i_req & ~o_valid;
    end
    if (i_req != 0) begin
      tests++;
      fails++;
      $display("FAIL serve_timeout: pending %b, required none", i_req);
      i_req = '0;
    end
  endtask
  task automatic wait_gnt(input logic [3:0] m);
    int i;
    for (i = 0; i < 100 && (o_gnt & m) == 0; i++) @(negedge i_clk);
    if ((o_gnt & m) == 0) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout: gnt %b, required one of %b", o_gnt, m);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge i_clk);
    repeat (2) @(negedge i_clk);
    chk("drain_left", sb.size(), 0);
  endtask
  initial begin
    reset_dut();
    set_op(2, 32'h0000C000, 32'h00010000);
    expect_v(4'b0100, 32'h00018000, 1'b0);
    serve(4'b0100);
    drain();
    reset_dut();
    for (int k = 0; k < 4; k++) set_op(k, (k + 1) << 15, 32'h00010000);
    expect_v(4'b0001, 32'h00010000, 1'b0);
    expect_v(4'b0010, 32'h00020000, 1'b0);
    serve(4'b0011);
    drain();
    reset_dut();
    expect_v(4'b0001, 32'h00010000, 1'b0);
    expect_v(4'b0010, 32'h00020000, 1'b0);
    expect_v(4'b0100, 32'h00030000, 1'b0);
    expect_v(4'b1000, 32'h00040000, 1'b0);
    expect_v(4'b0001, 32'h00010000, 1'b0);
    i_req = 4'hf;
    n = 0;
    for (int i = 0; i < 2000 && n < 5; i++) begin
      @(negedge i_clk);
      if (o_valid != 0) n++;
    end
    i_req = '0;
    chk("rr_pulses", n, 5);
    drain();
    set_op(1, 32'h8000C000, 32'h00010000);
    expect_v(4'b0010, 32'h80018000, 1'b0);
    serve(4'b0010);
    drain();
    force_ovf = 1'b1;
    expect_v(4'b0010, 32'h80018000, 1'b1);
    serve(4'b0010);
    drain();
    force_ovf = 1'b0;
    set_op(3, 32'h00004000, 32'h00006000);
    expect_v(4'b1000, 32'h00003000, 1'b0);
    i_req = 4'b1000;
    wait_gnt(4'b1000);
    set_op(3, 32'h7FFFFFFF, 32'h7FFFFFFF);
    i_req = '0;
    drain();
    set_op(0, 32'h00008000, 32'h00008000);
    set_op(1, 32'h00008000, 32'h00008000);
    stuck = 1'b1;
    sb.push_back('{err: 1'b1, vld: 4'b0000, res: 32'h0, ovf: 1'b0});
    expect_v(4'b0010, 32'h00008000, 1'b0);
    i_req = 4'b0011;
    n = 0;
    for (int i = 0; i < 400 && !o_error; i++) @(negedge i_clk);
    chk("watchdog_fired", o_error, 1);
    stuck = 1'b0;
    serve(4'b0010);
    drain();
    set_op(2, 32'h0000C000, 32'h00010000);
    i_req = 4'b0100;
    wait_gnt(4'b0100);
    repeat (3) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", o_gnt, 0);
    chk("async_rst_valid_result", {o_valid, o_result}, 0);
    chk("async_rst_flags", {o_overflow, o_error, o_mul_start}, 0);
    chk("async_rst_ops", {o_mul_multiplicand, o_mul_multiplier}, 0);
    i_req = 4'b0101;
    set_op(0, 32'h00008000, 32'h00008000);
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("hold_while_mul_busy", o_gnt, 0);
    expect_v(4'b0001, 32'h00008000, 1'b0);
    wait_gnt(4'b1111);
    chk("post_reset_gnt", o_gnt, 4'b0001);
    i_req = '0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
